comparator_bist: RTL and testbench

Built-in self-test driver for the 2-bit magnitude comparator. It drives every operand pair onto the comparator's `a`/`b` inputs and samples the comparator's `gt`/`eq`/`lt` flags. Each sample is checked against a golden model, and the block reports pass/fail, the error count and the first failing vector. It sits beside the comparator in the test wrapper and is the stimulus/checking end of the comparator interface.

---
 rtl/comparator_bist_pkg.sv | 35 +++
 rtl/comparator_bist_seq.sv | 49 ++++
 rtl/comparator_bist.sv | 140 ++++++++++++++
 tb/tb_comparator_bist.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_bist_pkg.sv
// rtl/comparator_bist_pkg.sv - shared FSM state type and golden comparator model for comparator_bist
package comparator_bist_pkg;

    // Run sequencing states of the BIST controller
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } bist_state_t;

    // Widest operand the golden model can evaluate
    localparam int MAX_WIDTH = 16;

    // Expected {gt,eq,lt} for unsigned operands a and b of the given width.
    // Bits above the operand width are masked so callers may zero-extend freely.
    function automatic logic [2:0] expected_flags(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] am;
        logic [MAX_WIDTH-1:0] bm;
        if (width >= MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        end
        am = a & mask;
        bm = b & mask;
        return {am > bm, am == bm, am < bm};
    endfunction

endpackage

// File: rtl/comparator_bist_seq.sv
// rtl/comparator_bist_seq.sv - vector index counter and settle timer for comparator_bist
module comparator_bist_seq
    import comparator_bist_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               count,
    input  logic               step,
    output logic [2*WIDTH-1:0] index,
    output logic               sample,
    output logic               settle_last,
    output logic               last
);

    localparam int IW = 2 * WIDTH;
    // A zero settle time still needs a one-bit timer that simply stays at zero
    localparam int TW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(SETTLE_CYCLES);

    logic [TW-1:0] timer;

    // Index advances once per vector; the timer counts down the settle cycles of each vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
            timer <= '0;
        end else if (load) begin
            index <= '0;
            timer <= TIMER_LOAD;
        end else if (step) begin
            index <= index + IW'(1);
            timer <= TIMER_LOAD;
        end else if (count && (timer != '0)) begin
            timer <= timer - TW'(1);
        end
    end

    // Timer at zero means the operands have settled and flags may be sampled
    always_comb begin
        sample      = (timer == '0);
        settle_last = (timer == TW'(1));
        last        = &index;
    end

endmodule

// File: rtl/comparator_bist.sv
// rtl/comparator_bist.sv - exhaustive BIST driver and checker for a magnitude comparator
module comparator_bist
    import comparator_bist_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               first_fail_valid,
    output logic [2*WIDTH-1:0] first_fail_vec,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic               dut_gt,
    input  logic               dut_eq,
    input  logic               dut_lt
);

    localparam int IW    = 2 * WIDTH;
    localparam int EW    = 2 * WIDTH + 1;
    // With no settle time every vector is sampled in the cycle it is applied
    localparam bist_state_t VEC_ENTRY = (SETTLE_CYCLES == 0) ? CHECK : APPLY;

    bist_state_t   state;
    bist_state_t   state_next;
    logic          seq_load;
    logic          seq_count;
    logic          seq_step;
    logic [IW-1:0] index;
    logic          sample;
    logic          settle_last;
    logic          last;
    logic          check_en;
    logic [2:0]    exp_flags;
    logic          mismatch;

    comparator_bist_seq #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (seq_load),
        .count       (seq_count),
        .step        (seq_step),
        .index       (index),
        .sample      (sample),
        .settle_last (settle_last),
        .last        (last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and sequencer controls; start is only honoured in IDLE
    always_comb begin
        state_next = state;
        seq_load   = 1'b0;
        seq_count  = 1'b0;
        seq_step   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    seq_load   = 1'b1;
                    state_next = VEC_ENTRY;
                end
            end
            APPLY: begin
                seq_count = 1'b1;
                if (settle_last) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (last) begin
                    state_next = FINISH;
                end else begin
                    seq_step   = 1'b1;
                    state_next = VEC_ENTRY;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands come straight from the registered index; flags are checked against the golden model
    always_comb begin
        dut_a     = index[IW-1:WIDTH];
        dut_b     = index[WIDTH-1:0];
        busy      = (state == APPLY) || (state == CHECK);
        done      = (state == FINISH);
        check_en  = (state == CHECK) && sample;
        exp_flags = expected_flags(MAX_WIDTH'(dut_a), MAX_WIDTH'(dut_b), WIDTH);
        mismatch  = ({dut_gt, dut_eq, dut_lt} != exp_flags);
    end

    // Result registers: cleared on an accepted start, updated once per checked vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if ((state == IDLE) && start) begin
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (check_en) begin
            if (mismatch) begin
                err_count <= err_count + EW'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= index;
                end
            end
            // Pass must account for the error, if any, of this final vector
            if (last) begin
                pass <= (err_count == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_comparator_bist.sv
// tb/tb_comparator_bist.sv - directed self-checking bench for comparator_bist
module tb_comparator_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, ffv;
    logic [4:0] err_count;
    logic [3:0] ffvec;
    logic [1:0] dut_a, dut_b;
    logic       gt, eq, lt;
    logic [1:0] mode = 2'd0;

    logic       start0 = 1'b0;
    logic       busy0, done0, pass0, ffv0;
    logic [4:0] err_count0;
    logic [3:0] ffvec0;
    logic [1:0] a0, b0;
    logic       gt0, eq0, lt0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    comparator_bist #(.WIDTH(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(ffv), .first_fail_vec(ffvec),
        .dut_a(dut_a), .dut_b(dut_b),
        .dut_gt(gt), .dut_eq(eq), .dut_lt(lt)
    );

    comparator_bist #(.WIDTH(2), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0),
        .dut_a(a0), .dut_b(b0),
        .dut_gt(gt0), .dut_eq(eq0), .dut_lt(lt0)
    );

    // Comparator under test with selectable faults
    always_comb begin
        case (mode)
            2'd0:    {gt, eq, lt} = {dut_a > dut_b, dut_a == dut_b, dut_a < dut_b};
            2'd1:    {gt, eq, lt} = {dut_a > dut_b, 1'b0, dut_a < dut_b};
            2'd2:    {gt, eq, lt} = {dut_a < dut_b, dut_a == dut_b, dut_a > dut_b};
            default: {gt, eq, lt} = 3'b111;
        endcase
    end

    assign gt0 = a0 > b0;
    assign eq0 = a0 == b0;
    assign lt0 = a0 < b0;

    // Pulse start for one cycle and wait for done; cyc = cycles after acceptance, -1 on timeout
    task automatic launch_and_wait(output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        got = {busy, done, pass, err_count, ffv, ffvec, dut_a, dut_b, busy0, done0};
        checks++;
        if (got !== 20'd0) begin
            fails++;
            $display("FAIL reset_values: got %h expected 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got = {busy, done, pass, err_count, ffv, ffvec, dut_a, dut_b, busy0, done0};
        checks++;
        if (got !== 20'd0) begin
            fails++;
            $display("FAIL idle_after_reset: got %h expected 0", got);
        end
    endtask

    task automatic test_correct();
        int cyc;
        int k;
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %0b expected 1", busy);
        end
        while (!done && cyc < 200) begin
            if ((cyc % 2) == 1 && cyc <= 31) begin
                k = (cyc - 1) / 2;
                checks++;
                if ({dut_a, dut_b} !== k[3:0]) begin
                    fails++;
                    $display("FAIL operand_step: cycle %0d got %0d expected %0d", cyc, {dut_a, dut_b}, k);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 33 || done !== 1'b1) begin
            fails++;
            $display("FAIL correct_latency: got %0d expected 33", cyc);
        end
        checks++;
        if ({busy, pass, err_count, ffv} !== {1'b0, 1'b1, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL correct_result: busy=%0b pass=%0b err=%0d ffv=%0b expected busy=0 pass=1 err=0 ffv=0",
                     busy, pass, err_count, ffv);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pass !== 1'b1) begin
            fails++;
            $display("FAIL done_one_cycle: done=%0b pass=%0b expected done=0 pass=1", done, pass);
        end
    endtask

    task automatic test_faults();
        logic [1:0] modes [3] = '{2'd1, 2'd2, 2'd3};
        int         errs  [3] = '{4, 12, 16};
        int         vecs  [3] = '{0, 1, 0};
        int         cyc;
        for (int i = 0; i < 3; i++) begin
            mode = modes[i];
            launch_and_wait(cyc);
            checks++;
            if (cyc !== 33) begin
                fails++;
                $display("FAIL fault%0d_latency: got %0d expected 33", i, cyc);
            end
            checks++;
            if (err_count !== errs[i][4:0]) begin
                fails++;
                $display("FAIL fault%0d_err_count: got %0d expected %0d", i, err_count, errs[i]);
            end
            checks++;
            if (ffv !== 1'b1 || ffvec !== vecs[i][3:0]) begin
                fails++;
                $display("FAIL fault%0d_first_fail: valid=%0b vec=%0d expected valid=1 vec=%0d",
                         i, ffv, ffvec, vecs[i]);
            end
            checks++;
            if (pass !== 1'b0) begin
                fails++;
                $display("FAIL fault%0d_pass: got %0b expected 0", i, pass);
            end
            @(negedge clk);
        end
        mode = 2'd0;
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        int done_cyc = -1;
        logic pass_at_done = 1'b0;
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    pass_at_done = pass;
                end
            end
            start = (cyc == 5 || cyc == 20);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || done_cyc !== 33) begin
            fails++;
            $display("FAIL start_ignored: done pulses %0d at cycle %0d expected 1 at 33", ndone, done_cyc);
        end
        checks++;
        if (pass_at_done !== 1'b1) begin
            fails++;
            $display("FAIL start_ignored_pass: got %0b expected 1", pass_at_done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] got;
        int          seen_done = 0;
        int          cyc;
        mode = 2'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (err_count !== 5'd1 || ffv !== 1'b1 || {dut_a, dut_b} !== 4'd4) begin
            fails++;
            $display("FAIL pre_reset_state: err=%0d ffv=%0b vec=%0d expected err=1 ffv=1 vec=4",
                     err_count, ffv, {dut_a, dut_b});
        end
        rst_n = 1'b0;
        #1;
        got = {busy, done, pass, err_count, ffv, ffvec, dut_a, dut_b};
        checks++;
        if (got !== 16'd0) begin
            fails++;
            $display("FAIL async_reset_values: got %h expected 0", got);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            fails++;
            $display("FAIL no_done_after_reset: got %0d active cycles expected 0", seen_done);
        end
        mode = 2'd0;
        launch_and_wait(cyc);
        checks++;
        if (cyc !== 33 || pass !== 1'b1 || err_count !== 5'd0 || ffv !== 1'b0) begin
            fails++;
            $display("FAIL rerun_after_reset: cyc=%0d pass=%0b err=%0d ffv=%0b expected 33 1 0 0",
                     cyc, pass, err_count, ffv);
        end
        @(negedge clk);
    endtask

    task automatic test_settle_zero();
        int cyc;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 17 || done0 !== 1'b1) begin
            fails++;
            $display("FAIL settle0_latency: got %0d expected 17", cyc);
        end
        checks++;
        if (pass0 !== 1'b1 || err_count0 !== 5'd0 || ffv0 !== 1'b0) begin
            fails++;
            $display("FAIL settle0_result: pass=%0b err=%0d ffv=%0b expected 1 0 0", pass0, err_count0, ffv0);
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_correct();
        test_faults();
        test_start_ignored();
        test_reset_mid_run();
        test_settle_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
